// File: rtl/bk_spi_pkg.sv
// Shared types and constants for the BK user-register SPI master engine.
package bk_spi_pkg;
  typedef enum logic {
    SPI_IDLE  = 1'b0,
    SPI_SHIFT = 1'b1
  } spi_state_e;

  localparam int                  SPI_BITS   = 8;
  localparam int                  SPI_EDGES  = 16;
  localparam int                  EDGE_W     = $clog2(SPI_EDGES);
  localparam logic                MOSI_IDLE  = 1'b1;
  localparam logic [SPI_BITS-1:0] DATA_RESET = 8'hFF;
endpackage

// File: rtl/bk_spi_if.sv
// Core-side register strobe/data plus the SPI pins, bundled for the engine.
interface bk_spi_if;
  import bk_spi_pkg::*;

  logic                ce;
  logic                wren;
  logic [SPI_BITS-1:0] data_i;
  logic                cs_n_i;
  logic [SPI_BITS-1:0] data_o;
  logic                dsr;
  logic                overrun;
  logic                sck;
  logic                mosi;
  logic                miso;
  logic                ss_n;

  modport master (
    input  ce, wren, data_i, cs_n_i, miso,
    output data_o, dsr, overrun, sck, mosi, ss_n
  );

  modport slave (
    output ce, wren, data_i, cs_n_i, miso,
    input  data_o, dsr, overrun, sck, mosi, ss_n
  );
endinterface

// File: rtl/bk_spi_sckgen.sv
// Half-period divider: registered tick one cycle before each sck toggle, so
// the engine acts on the same edge that sck changes.
module bk_spi_sckgen #(
  parameter int CLKDIV = 4,
  parameter int DIV_W  = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic sck
);
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLKDIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sck_q, sck_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    sck_d  = sck_q;
    if (clr) begin
      cnt_d = RELOAD;
      sck_d = 1'b0;
    end else if (en) begin
      tick_d = (cnt_q == '0);
      cnt_d  = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
      if (tick_q) sck_d = ~sck_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sck_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sck_q  <= sck_d;
    end
  end

  // A tick left over from the last divider period is ignored once idle.
  assign tick = tick_q & en;
  assign sck  = sck_q;
endmodule

// File: rtl/bk_spi_master.sv
// Byte-wide SPI mode-0 master for register 177714 with a one-byte holding
// register so the CPU can queue the next byte during a transfer.
module bk_spi_master
  import bk_spi_pkg::*;
#(
  parameter int CLKDIV = 4,
  parameter int DIV_W  = 8
) (
  input logic      clk,
  input logic      reset_n,
  bk_spi_if.master bus
);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(SPI_EDGES - 1);

  spi_state_e          state_q, state_d;
  logic [SPI_BITS-1:0] tx_q, tx_d;
  logic [SPI_BITS-1:0] rx_q, rx_d;
  logic [SPI_BITS-1:0] hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [SPI_BITS-1:0] data_q, data_d;
  logic                ss_n_q, ss_n_d;
  logic                dsr_q, dsr_d;
  logic                overrun_q, overrun_d;
  logic                accept, clr, tick, sck;

  bk_spi_sckgen #(.CLKDIV(CLKDIV), .DIV_W(DIV_W)) u_sckgen (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .en     (state_q == SPI_SHIFT),
    .tick   (tick),
    .sck    (sck)
  );

  assign accept = bus.ce & bus.wren;

  // NOTE: every variable gets its default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    edge_cnt_d   = edge_cnt_q;
    data_d       = data_q;
    overrun_d    = overrun_q;
    clr          = 1'b0;

    unique case (state_q)
      SPI_IDLE: begin
        if (accept) begin
          tx_d       = bus.data_i;
          edge_cnt_d = '0;
          overrun_d  = 1'b0;
          clr        = 1'b1;
          state_d    = SPI_SHIFT;
        end
      end
      SPI_SHIFT: begin
        if (accept) begin
          if (!hold_valid_q) begin
            hold_d       = bus.data_i;
            hold_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        // Later statements read hold_*_d so a write landing on the final edge is chained.
        if (tick) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
          if (!sck) begin
            rx_d = {rx_q[SPI_BITS-2:0], bus.miso};
          end else if (edge_cnt_q == LAST_EDGE) begin
            data_d = rx_q;
            if (hold_valid_d) begin
              tx_d         = hold_d;
              hold_valid_d = 1'b0;
            end else begin
              tx_d    = {SPI_BITS{MOSI_IDLE}};
              state_d = SPI_IDLE;
            end
          end else begin
            tx_d = {tx_q[SPI_BITS-2:0], MOSI_IDLE};
          end
        end
      end
      default: state_d = SPI_IDLE;
    endcase

    ss_n_d = (state_q == SPI_IDLE) ? bus.cs_n_i : ss_n_q;
    dsr_d  = (state_d == SPI_IDLE) & ~hold_valid_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SPI_IDLE;
      tx_q         <= {SPI_BITS{MOSI_IDLE}};
      rx_q         <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      edge_cnt_q   <= '0;
      data_q       <= DATA_RESET;
      ss_n_q       <= 1'b1;
      dsr_q        <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      edge_cnt_q   <= edge_cnt_d;
      data_q       <= data_d;
      ss_n_q       <= ss_n_d;
      dsr_q        <= dsr_d;
      overrun_q    <= overrun_d;
    end
  end

  // mosi is the tx MSB; idle and fill bits are MOSI_IDLE so the line rests high.
  assign bus.mosi    = tx_q[SPI_BITS-1];
  assign bus.sck     = sck;
  assign bus.ss_n    = ss_n_q;
  assign bus.data_o  = data_q;
  assign bus.dsr     = dsr_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_bk_spi_master.sv
// Directed bench: dut A (CLKDIV=2, miso looped to mosi), dut B (CLKDIV=1, miso=0).
module tb_bk_spi_master;
  import bk_spi_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   edges_a = 0;
  logic mosi_log_a[$];
  logic mosi_log_b[$];

  always #5 clk = ~clk;

  bk_spi_if ifa ();
  bk_spi_if ifb ();

  bk_spi_master #(.CLKDIV(2), .DIV_W(8)) u_dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  bk_spi_master #(.CLKDIV(1), .DIV_W(8)) u_dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  assign ifa.miso = ifa.mosi;
  assign ifb.miso = 1'b0;

  always @(ifa.sck) edges_a = edges_a + 1;
  always @(posedge ifa.sck) mosi_log_a.push_back(ifa.mosi);
  always @(posedge ifb.sck) mosi_log_b.push_back(ifb.mosi);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [7:0] b);
    ifa.data_i = b; ifa.wren = 1'b1; ifa.ce = 1'b1;
    step();
    ifa.wren = 1'b0; ifa.ce = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] b);
    ifb.data_i = b; ifb.wren = 1'b1; ifb.ce = 1'b1;
    step();
    ifb.wren = 1'b0; ifb.ce = 1'b0;
  endtask

  task automatic wait_done_a(input int max);
    for (int i = 0; i < max; i++) begin
      if (ifa.dsr === 1'b1) break;
      step();
    end
    checks++;
    if (ifa.dsr !== 1'b1) begin
      errors++; $display("FAIL wait_done_a: dsr=%b required 1 within %0d cycles", ifa.dsr, max);
    end
  endtask

  function automatic logic [15:0] log_bits_a(input int base, input int n);
    logic [15:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[14:0], mosi_log_a[base+i]};
    return v;
  endfunction

  function automatic logic [15:0] log_bits_b(input int base, input int n);
    logic [15:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[14:0], mosi_log_b[base+i]};
    return v;
  endfunction

  task automatic test_reset();
    {ifa.ce, ifa.wren, ifa.data_i, ifa.cs_n_i} = {1'b0, 1'b0, 8'h00, 1'b1};
    {ifb.ce, ifb.wren, ifb.data_i, ifb.cs_n_i} = {1'b0, 1'b0, 8'h00, 1'b1};
    reset_n = 1'b0;
    #12;
    checks++;
    if ({ifa.sck, ifa.mosi, ifa.ss_n, ifa.dsr, ifa.overrun, ifa.data_o} !== {5'b01110, 8'hFF}) begin
      errors++; $display("FAIL reset_a: {sck,mosi,ss_n,dsr,ovr,data}=%b_%h required 01110_ff",
        {ifa.sck, ifa.mosi, ifa.ss_n, ifa.dsr, ifa.overrun}, ifa.data_o);
    end
    checks++;
    if ({ifb.sck, ifb.mosi, ifb.ss_n, ifb.dsr, ifb.overrun, ifb.data_o} !== {5'b01110, 8'hFF}) begin
      errors++; $display("FAIL reset_b: {sck,mosi,ss_n,dsr,ovr,data}=%b_%h required 01110_ff",
        {ifb.sck, ifb.mosi, ifb.ss_n, ifb.dsr, ifb.overrun}, ifb.data_o);
    end
    @(negedge clk) reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int base_e = edges_a;
    int base_m = mosi_log_a.size();
    write_a(8'hA5);
    checks++;
    if (ifa.dsr !== 1'b0) begin errors++; $display("FAIL single_busy: dsr=%b required 0", ifa.dsr); end
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 2) begin
        checks++;
        if (ifa.sck !== 1'b0) begin errors++; $display("FAIL single_sck_pre: sck=%b required 0", ifa.sck); end
      end
      if (i == 3) begin
        checks++;
        if (ifa.sck !== 1'b1) begin errors++; $display("FAIL single_first_rise: sck=%b required 1", ifa.sck); end
      end
    end
    checks++;
    if ({ifa.dsr, ifa.data_o} !== {1'b0, 8'hFF}) begin
      errors++; $display("FAIL single_t32: dsr=%b data=%h required 0 ff", ifa.dsr, ifa.data_o);
    end
    step();
    checks++;
    if ({ifa.dsr, ifa.data_o} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL single_t33: dsr=%b data=%h required 1 a5", ifa.dsr, ifa.data_o);
    end
    checks++;
    if (edges_a - base_e != 16) begin
      errors++; $display("FAIL single_edges: got %0d required 16", edges_a - base_e);
    end
    checks++;
    if (log_bits_a(base_m, 8) !== 16'h00A5 || mosi_log_a.size() - base_m != 8) begin
      errors++; $display("FAIL single_mosi: got %h (%0d bits) required a5 (8 bits)",
        log_bits_a(base_m, 8), mosi_log_a.size() - base_m);
    end
  endtask

  task automatic test_queued();
    int base_m = mosi_log_b.size();
    int busy_bad = 0;
    write_b(8'h3C);
    repeat (3) step();
    write_b(8'hC3);
    for (int i = 5; i <= 33; i++) begin
      step();
      if (i < 33 && ifb.dsr !== 1'b0) busy_bad++;
      if (i == 17) begin
        checks++;
        if (ifb.data_o !== 8'h00) begin errors++; $display("FAIL queued_byte1: data=%h required 00", ifb.data_o); end
      end
      if (i == 18) begin
        checks++;
        if (ifb.sck !== 1'b1) begin errors++; $display("FAIL queued_no_gap: sck=%b required 1", ifb.sck); end
      end
    end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL queued_busy: dsr high %0d cycles required 0", busy_bad); end
    checks++;
    if ({ifb.dsr, ifb.overrun, ifb.data_o} !== {2'b10, 8'h00}) begin
      errors++; $display("FAIL queued_done: dsr=%b ovr=%b data=%h required 1 0 00",
        ifb.dsr, ifb.overrun, ifb.data_o);
    end
    checks++;
    if (log_bits_b(base_m, 16) !== 16'h3CC3 || mosi_log_b.size() - base_m != 16) begin
      errors++; $display("FAIL queued_mosi: got %h required 3cc3", log_bits_b(base_m, 16));
    end
  endtask

  task automatic test_overrun();
    int base_m = mosi_log_a.size();
    write_a(8'h11);
    repeat (2) step();
    write_a(8'h22);
    repeat (2) step();
    write_a(8'h33);
    checks++;
    if (ifa.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: ovr=%b required 1", ifa.overrun); end
    wait_done_a(100);
    checks++;
    if (log_bits_a(base_m, 16) !== 16'h1122 || mosi_log_a.size() - base_m != 16) begin
      errors++; $display("FAIL overrun_mosi: got %h (%0d bits) required 1122 (16 bits)",
        log_bits_a(base_m, 16), mosi_log_a.size() - base_m);
    end
    checks++;
    if ({ifa.overrun, ifa.data_o} !== {1'b1, 8'h22}) begin
      errors++; $display("FAIL overrun_sticky: ovr=%b data=%h required 1 22", ifa.overrun, ifa.data_o);
    end
    step();
    write_a(8'h44);
    checks++;
    if (ifa.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: ovr=%b required 0", ifa.overrun); end
    wait_done_a(100);
    checks++;
    if (ifa.data_o !== 8'h44) begin errors++; $display("FAIL overrun_next: data=%h required 44", ifa.data_o); end
  endtask

  task automatic test_ce_gating();
    int base_e = edges_a;
    int base_m = mosi_log_a.size();
    ifa.data_i = 8'h5A; ifa.wren = 1'b1; ifa.ce = 1'b0;
    repeat (2) step();
    checks++;
    if (ifa.dsr !== 1'b1) begin errors++; $display("FAIL ce_no_accept: dsr=%b required 1", ifa.dsr); end
    ifa.ce = 1'b1;
    step();
    ifa.ce = 1'b0;
    repeat (3) step();
    ifa.wren = 1'b0;
    wait_done_a(100);
    repeat (5) step();
    checks++;
    if (ifa.dsr !== 1'b1 || edges_a - base_e != 16 || mosi_log_a.size() - base_m != 8 || ifa.data_o !== 8'h5A) begin
      errors++; $display("FAIL ce_single: dsr=%b edges=%0d bits=%0d data=%h required 1 16 8 5a",
        ifa.dsr, edges_a - base_e, mosi_log_a.size() - base_m, ifa.data_o);
    end
  endtask

  task automatic test_cs();
    int frozen_bad = 0;
    ifa.cs_n_i = 1'b0;
    step();
    checks++;
    if (ifa.ss_n !== 1'b0) begin errors++; $display("FAIL cs_idle_follow: ss_n=%b required 0", ifa.ss_n); end
    write_a(8'h96);
    repeat (4) step();
    ifa.cs_n_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (ifa.ss_n !== 1'b0) frozen_bad++;
      if (ifa.dsr === 1'b1) break;
      step();
    end
    checks++;
    if (frozen_bad != 0 || ifa.dsr !== 1'b1) begin
      errors++; $display("FAIL cs_frozen: ss_n high %0d samples dsr=%b required 0 samples dsr=1", frozen_bad, ifa.dsr);
    end
    step();
    checks++;
    if (ifa.ss_n !== 1'b1) begin errors++; $display("FAIL cs_release: ss_n=%b required 1", ifa.ss_n); end
  endtask

  task automatic test_reset_mid();
    int base_e = edges_a;
    int base_m;
    write_a(8'hC7);
    for (int i = 0; i < 100; i++) begin
      if (edges_a - base_e >= 5) break;
      step();
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ifa.sck, ifa.mosi, ifa.ss_n, ifa.dsr, ifa.data_o} !== {4'b0111, 8'hFF} || edges_a - base_e < 5) begin
      errors++; $display("FAIL reset_mid: {sck,mosi,ss_n,dsr,data}=%b_%h edges=%0d required 0111_ff edges>=5",
        {ifa.sck, ifa.mosi, ifa.ss_n, ifa.dsr}, ifa.data_o, edges_a - base_e);
    end
    @(negedge clk) reset_n = 1'b1;
    step();
    base_m = mosi_log_a.size();
    write_a(8'h3E);
    wait_done_a(100);
    checks++;
    if (ifa.data_o !== 8'h3E || log_bits_a(base_m, 8) !== 16'h003E) begin
      errors++; $display("FAIL reset_post_write: data=%h mosi=%h required 3e 3e", ifa.data_o, log_bits_a(base_m, 8));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queued();
    test_overrun();
    test_ce_gating();
    test_cs();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
